// File: rtl/ren_conv_engine_v2.sv
// Multi-channel masked 1-D convolution core: issues image/kernel reads, accumulates
// per-channel products, then requantises, optionally 2:1 max-pools and writes one byte.
module ren_conv_engine_v2 #(
    parameter int CH              = 3,
    parameter int DW              = 8,
    parameter int KERN_COL_WIDTH  = 3,
    parameter int COL_WIDTH       = 8,
    parameter int KERN_CNT_WIDTH  = 3,
    parameter int IMG_ADDR_WIDTH  = 6,
    parameter int KERN_ADDR_WIDTH = 6,
    parameter int RSLT_ADDR_WIDTH = 6,
    parameter int ACC_WIDTH       = 24
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       soft_rst,
    input  logic                       start,
    input  logic [KERN_COL_WIDTH-1:0]  cfg_kern_cols,
    input  logic [COL_WIDTH-1:0]       cfg_cols,
    input  logic [KERN_CNT_WIDTH-1:0]  cfg_kerns,
    input  logic [COL_WIDTH-1:0]       cfg_stride,
    input  logic                       cfg_kern_addr_mode,
    input  logic [4:0]                 cfg_shift,
    input  logic                       cfg_en_max_pool,
    input  logic                       cfg_saturate,
    input  logic [CH-1:0]              cfg_mask,
    output logic [IMG_ADDR_WIDTH-1:0]  img_addr_o,
    input  logic [CH*DW-1:0]           img_data_i,
    output logic [KERN_ADDR_WIDTH-1:0] kern_addr_o,
    input  logic [CH*DW-1:0]           kern_data_i,
    output logic                       rslt_we_o,
    output logic [RSLT_ADDR_WIDTH-1:0] rslt_addr_o,
    output logic [DW-1:0]              rslt_data_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       ovf_o
);

    typedef enum logic [2:0] {IDLE, ISSUE, LAST, WRITE, DONE} state_t;

    state_t state_reg, state_next;

    logic                       start_s_reg, start_d_reg;
    logic [KERN_COL_WIDTH-1:0]  kern_cols_reg;
    logic [COL_WIDTH-1:0]       cols_reg;
    logic [KERN_CNT_WIDTH-1:0]  kerns_reg;
    logic [COL_WIDTH-1:0]       stride_reg;
    logic                       mode_reg;
    logic [4:0]                 shift_reg;
    logic                       pool_reg;
    logic                       sat_reg;
    logic [CH-1:0]              mask_reg;

    logic [KERN_COL_WIDTH-1:0]  kc_reg;
    logic [COL_WIDTH-1:0]       c_reg;
    logic [KERN_CNT_WIDTH-1:0]  k_reg;
    logic [IMG_ADDR_WIDTH-1:0]  img_base_reg;
    logic [KERN_ADDR_WIDTH-1:0] kern_base_reg;
    logic [RSLT_ADDR_WIDTH-1:0] rslt_addr_reg;
    logic [ACC_WIDTH-1:0]       acc_reg;
    logic [ACC_WIDTH-1:0]       hold_reg;
    logic                       mac_valid_reg;
    logic                       busy_reg, done_reg, ovf_reg;

    logic                       start_edge;
    logic [KERN_ADDR_WIDTH-1:0] kern_step;
    logic [2*DW-1:0]            prod [CH];
    logic [ACC_WIDTH-1:0]       mac_sum;
    logic                       last_col, last_kern, do_write, over;
    logic [ACC_WIDTH-1:0]       pool_val, q;

    assign start_edge = start_s_reg & ~start_d_reg & (state_reg == IDLE);
    assign kern_step  = mode_reg ? KERN_ADDR_WIDTH'(8) : KERN_ADDR_WIDTH'(4);
    assign last_col   = (c_reg == cols_reg);
    assign last_kern  = (k_reg == kerns_reg);

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : gen_prod
            assign prod[gi] = mask_reg[gi]
                ? img_data_i[gi*DW +: DW] * kern_data_i[gi*DW +: DW]
                : '0;
        end
    endgenerate

    always_comb begin
        mac_sum = '0;
        for (int i = 0; i < CH; i++) begin
            mac_sum = mac_sum + ACC_WIDTH'(prod[i]);
        end
    end

    // Even pooled columns only park their sum; an odd column (or an odd trailing one) writes.
    assign do_write = ~pool_reg | c_reg[0] | last_col;
    assign pool_val = (pool_reg && c_reg[0] && hold_reg > acc_reg) ? hold_reg : acc_reg;
    assign q        = pool_val >> shift_reg;
    assign over     = |q[ACC_WIDTH-1:DW];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg <= IDLE;
        end else if (soft_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        img_addr_o  = '0;
        kern_addr_o = '0;
        rslt_we_o   = 1'b0;
        rslt_addr_o = '0;
        rslt_data_o = '0;
        case (state_reg)
            IDLE: begin
                if (start_edge) state_next = ISSUE;
            end
            ISSUE: begin
                img_addr_o  = img_base_reg + IMG_ADDR_WIDTH'(kc_reg);
                kern_addr_o = kern_base_reg + KERN_ADDR_WIDTH'(kc_reg);
                if (kc_reg == kern_cols_reg) state_next = LAST;
            end
            LAST: begin
                state_next = WRITE;
            end
            WRITE: begin
                rslt_we_o   = do_write;
                rslt_addr_o = rslt_addr_reg;
                rslt_data_o = (over && sat_reg) ? {DW{1'b1}} : q[DW-1:0];
                state_next  = (last_col && last_kern) ? DONE : ISSUE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i || soft_rst) begin
            start_s_reg   <= 1'b0;
            start_d_reg   <= 1'b0;
            kern_cols_reg <= '0;
            cols_reg      <= '0;
            kerns_reg     <= '0;
            stride_reg    <= '0;
            mode_reg      <= 1'b0;
            shift_reg     <= '0;
            pool_reg      <= 1'b0;
            sat_reg       <= 1'b0;
            mask_reg      <= '0;
            kc_reg        <= '0;
            c_reg         <= '0;
            k_reg         <= '0;
            img_base_reg  <= '0;
            kern_base_reg <= '0;
            rslt_addr_reg <= '0;
            acc_reg       <= '0;
            hold_reg      <= '0;
            mac_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            start_s_reg   <= start;
            start_d_reg   <= start_s_reg;
            // SRAM data lags the address by one cycle, so MAC trails ISSUE by one.
            mac_valid_reg <= (state_reg == ISSUE);
            if (mac_valid_reg) acc_reg <= acc_reg + mac_sum;
            case (state_reg)
                IDLE: begin
                    if (start_edge) begin
                        kern_cols_reg <= cfg_kern_cols;
                        cols_reg      <= cfg_cols;
                        kerns_reg     <= cfg_kerns;
                        stride_reg    <= (cfg_stride == '0) ? COL_WIDTH'(1) : cfg_stride;
                        mode_reg      <= cfg_kern_addr_mode;
                        shift_reg     <= cfg_shift;
                        pool_reg      <= cfg_en_max_pool;
                        sat_reg       <= cfg_saturate;
                        mask_reg      <= cfg_mask;
                        kc_reg        <= '0;
                        c_reg         <= '0;
                        k_reg         <= '0;
                        img_base_reg  <= '0;
                        kern_base_reg <= '0;
                        rslt_addr_reg <= '0;
                        acc_reg       <= '0;
                        hold_reg      <= '0;
                        busy_reg      <= 1'b1;
                        done_reg      <= 1'b0;
                        ovf_reg       <= 1'b0;
                    end
                end
                ISSUE: begin
                    kc_reg <= (kc_reg == kern_cols_reg) ? '0 : kc_reg + 1'b1;
                end
                WRITE: begin
                    acc_reg <= '0;
                    if (pool_reg && !c_reg[0]) hold_reg <= acc_reg;
                    if (do_write) begin
                        rslt_addr_reg <= rslt_addr_reg + 1'b1;
                        if (over) ovf_reg <= 1'b1;
                    end
                    if (last_col) begin
                        c_reg        <= '0;
                        img_base_reg <= '0;
                        if (!last_kern) begin
                            k_reg         <= k_reg + 1'b1;
                            kern_base_reg <= kern_base_reg + kern_step;
                        end
                    end else begin
                        c_reg        <= c_reg + 1'b1;
                        img_base_reg <= img_base_reg + IMG_ADDR_WIDTH'(stride_reg);
                    end
                end
                DONE: begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy_o = busy_reg;
    assign done_o = done_reg;
    assign ovf_o  = ovf_reg;

endmodule

// File: tb/tb_ren_conv_engine_v2.sv
// Randomised and directed bench for ren_conv_engine_v2 against a loop-based reference model.
module tb_ren_conv_engine_v2;

    logic        clk = 1'b0;
    logic        rst, soft_rst, start;
    logic [2:0]  cfg_kern_cols;
    logic [7:0]  cfg_cols;
    logic [2:0]  cfg_kerns;
    logic [7:0]  cfg_stride;
    logic        cfg_kern_addr_mode;
    logic [4:0]  cfg_shift;
    logic        cfg_en_max_pool, cfg_saturate;
    logic [2:0]  cfg_mask;
    logic [5:0]  img_addr, kern_addr, rslt_addr;
    logic [23:0] img_data, kern_data;
    logic        rslt_we, busy, done, ovf;
    logic [7:0]  rslt_data;

    logic [23:0] img_mem  [64];
    logic [23:0] kern_mem [64];

    int n_pass  = 0;
    int n_total = 0;
    int job_id  = 0;

    int     got_a [$];
    int     got_d [$];
    int     exp_a [$];
    int     exp_d [$];
    int     exp_ovf;

    always #5 clk = ~clk;

    ren_conv_engine_v2 dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .soft_rst(soft_rst), .start(start),
        .cfg_kern_cols(cfg_kern_cols), .cfg_cols(cfg_cols), .cfg_kerns(cfg_kerns),
        .cfg_stride(cfg_stride), .cfg_kern_addr_mode(cfg_kern_addr_mode),
        .cfg_shift(cfg_shift), .cfg_en_max_pool(cfg_en_max_pool),
        .cfg_saturate(cfg_saturate), .cfg_mask(cfg_mask),
        .img_addr_o(img_addr), .img_data_i(img_data),
        .kern_addr_o(kern_addr), .kern_data_i(kern_data),
        .rslt_we_o(rslt_we), .rslt_addr_o(rslt_addr), .rslt_data_o(rslt_data),
        .busy_o(busy), .done_o(done), .ovf_o(ovf)
    );

    always @(posedge clk) begin
        img_data  <= img_mem[img_addr];
        kern_data <= kern_mem[kern_addr];
    end

    always @(negedge clk) begin
        if (rslt_we) begin
            got_a.push_back(int'(rslt_addr));
            got_d.push_back(int'(rslt_data));
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference: compute every column sum directly, then pair columns for pooling.
    task automatic model(input int nk, input int nc, input int nn, input int stride,
                         input int mode, input int shift, input int pool, input int sat,
                         input int mask);
        longint col [$];
        longint v, q;
        int     wa = 0;
        int     st = (stride == 0) ? 1 : stride;
        exp_a.delete(); exp_d.delete(); exp_ovf = 0;
        for (int k = 0; k < nn; k++) begin
            col.delete();
            for (int c = 0; c < nc; c++) begin
                longint acc = 0;
                for (int kc = 0; kc < nk; kc++) begin
                    int ia = (c * st + kc) % 64;
                    int ka = (k * (4 << mode) + kc) % 64;
                    for (int ch = 0; ch < 3; ch++)
                        if (((mask >> ch) & 1) == 1)
                            acc += longint'(img_mem[ia][ch*8 +: 8]) * longint'(kern_mem[ka][ch*8 +: 8]);
                end
                col.push_back(acc);
            end
            for (int c = 0; c < nc; c += (pool != 0) ? 2 : 1) begin
                v = col[c];
                if (pool != 0 && c + 1 < nc && col[c+1] > v) v = col[c+1];
                q = v >> shift;
                if (q > 255) exp_ovf = 1;
                exp_a.push_back(wa % 64);
                exp_d.push_back((q > 255 && sat != 0) ? 255 : int'(q % 256));
                wa++;
            end
        end
    endtask

    task automatic drive_cfg(input int nk, input int nc, input int nn, input int stride,
                             input int mode, input int shift, input int pool, input int sat,
                             input int mask);
        cfg_kern_cols      = 3'(nk - 1);
        cfg_cols           = 8'(nc - 1);
        cfg_kerns          = 3'(nn - 1);
        cfg_stride         = 8'(stride);
        cfg_kern_addr_mode = 1'(mode);
        cfg_shift          = 5'(shift);
        cfg_en_max_pool    = 1'(pool);
        cfg_saturate       = 1'(sat);
        cfg_mask           = 3'(mask);
    endtask

    task automatic run_job(input int nk, input int nc, input int nn, input int stride,
                           input int mode, input int shift, input int pool, input int sat,
                           input int mask, input bit restart_mid);
        int cycles = 0;
        int exp_cycles = nn * nc * (nk + 2) + 2;
        bit finished = 0;
        job_id++;
        model(nk, nc, nn, stride, mode, shift, pool, sat, mask);
        drive_cfg(nk, nc, nn, stride, mode, shift, pool, sat, mask);
        @(negedge clk);
        got_a.delete(); got_d.delete();
        start = 1'b1;
        @(posedge clk);
        while (cycles < 5000 && !finished) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (cycles == 1) begin
                check("busy_after_start", busy, 1);
                check("done_cleared", done, 0);
            end
            if (cycles == 3) begin
                start = 1'b0;
                cfg_kern_cols = 3'($urandom); cfg_cols = 8'($urandom);
                cfg_kerns = 3'($urandom); cfg_stride = 8'($urandom);
                cfg_shift = 5'($urandom); cfg_mask = 3'($urandom);
                cfg_en_max_pool = 1'($urandom); cfg_saturate = 1'($urandom);
                cfg_kern_addr_mode = 1'($urandom);
            end
            if (restart_mid && exp_cycles > 20 && cycles == 6) start = 1'b1;
            if (restart_mid && exp_cycles > 20 && cycles == 8) start = 1'b0;
            if (done) finished = 1;
        end
        check("job_timeout", finished, 1);
        check("cycles", cycles, exp_cycles);
        check("busy_end", busy, 0);
        check("ovf", ovf, exp_ovf);
        check("write_count", got_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            $display("job %0d write %0d: addr %0d data %0d (model addr %0d data %0d)",
                     job_id, i, got_a[i], got_d[i], exp_a[i], exp_d[i]);
            check("wr_addr", got_a[i], exp_a[i]);
            check("wr_data", got_d[i], exp_d[i]);
        end
    endtask

    task automatic start_only();
        drive_cfg(2, 8, 3, 1, 0, 0, 0, 1, 7);
        @(negedge clk);
        start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic fill_ones();
        for (int i = 0; i < 64; i++) begin
            img_mem[i]  = 24'h010101;
            kern_mem[i] = 24'h010101;
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; soft_rst = 1'b0; start = 1'b0;
        drive_cfg(1, 1, 1, 1, 0, 0, 0, 0, 0);
        fill_ones();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        check("rst_we", rslt_we, 0);
        check("rst_img_addr", img_addr, 0);
        check("rst_kern_addr", kern_addr, 0);

        // Basic: every channel 1, 24 writes of 6.
        run_job(2, 8, 3, 1, 0, 0, 0, 1, 7, 0);
        if (got_d.size() > 0) check("basic_first_value", got_d[0], 6);

        // Pooling with an odd column count.
        for (int i = 0; i < 64; i++) begin
            img_mem[i]  = 24'(i);
            kern_mem[i] = 24'h000001;
        end
        run_job(1, 5, 1, 1, 0, 0, 1, 1, 1, 0);
        if (got_d.size() == 3) begin
            check("pool_v0", got_d[0], 1);
            check("pool_v1", got_d[1], 3);
            check("pool_v2", got_d[2], 4);
        end

        // Stride 2 with kernel address mode 1.
        run_job(1, 4, 2, 2, 1, 0, 0, 1, 1, 0);
        if (got_d.size() == 8) check("stride_k1_c3", got_d[7], 6);

        // Saturation and truncation.
        for (int i = 0; i < 64; i++) begin
            img_mem[i]  = 24'hffffff;
            kern_mem[i] = 24'hffffff;
        end
        run_job(4, 1, 1, 1, 0, 8, 0, 1, 7, 0);
        if (got_d.size() == 1) check("sat_value", got_d[0], 255);
        run_job(4, 1, 1, 1, 0, 8, 0, 0, 7, 0);
        if (got_d.size() == 1) check("trunc_value", got_d[0], 232);

        // Random jobs; some try to restart while busy.
        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < 64; i++) begin
                img_mem[i]  = 24'($urandom);
                kern_mem[i] = 24'($urandom);
            end
            run_job(int'($urandom_range(1, 8)), int'($urandom_range(1, 10)),
                    int'($urandom_range(1, 8)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 20)),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 7)), (j % 2) == 1);
        end

        // Soft reset mid-job.
        fill_ones();
        start_only();
        soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
        n = got_a.size();
        check("srst_busy", busy, 0);
        check("srst_done", done, 0);
        repeat (50) @(negedge clk);
        check("srst_no_writes", got_a.size(), n);
        check("srst_done_later", done, 0);
        run_job(2, 8, 3, 1, 0, 0, 0, 1, 7, 0);

        // Asynchronous reset mid-job.
        start_only();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_we", rslt_we, 0);
        @(negedge clk);
        rst = 1'b0;
        n = got_a.size();
        repeat (50) @(negedge clk);
        check("arst_no_writes", got_a.size(), n);
        check("arst_done", done, 0);
        run_job(2, 8, 3, 1, 0, 0, 0, 1, 7, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
